// File: rtl/pc_fetch_unit.sv
// PC register and instruction fetch stage: issues imem fetches for pc and presents each word to decode.
// Optional ALIGN_CHECK_EN: a misaligned pc raises if_adel with NOP_INSTR instead of fetching.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] npc,
    output logic [31:0] npc4,
    output logic [31:0] pc,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_adel
);

    localparam int unsigned XLEN = 32;

`ifdef ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              req_q, req_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   if_pc_q, if_pc_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic              adel_q, adel_d;
    logic              misal_q_c, misal_d_c, fetch_ack_c;

    assign misal_q_c   = ALIGN_CHK && (pc_q[1:0] != 2'b00);
    assign misal_d_c   = ALIGN_CHK && (pc_d[1:0] != 2'b00);
    // An ack only counts against a request that is actually on the bus.
    assign fetch_ack_c = req_q && imem_ack;

    // Next-state and next-output computation.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        valid_d = 1'b0;
        if_pc_d = if_pc_q;
        instr_d = instr_q;
        adel_d  = adel_q;

        unique case (state_q)
            S_FETCH: begin
                if (flush) begin
                    pc_d    = flush_pc;
                    state_d = (req_q && !imem_ack) ? S_DISCARD : S_FETCH;
                end else if (misal_q_c) begin
                    state_d = S_HOLD;
                    if_pc_d = pc_q;
                    instr_d = NOP_INSTR;
                    adel_d  = 1'b1;
                end else if (fetch_ack_c) begin
                    state_d = S_HOLD;
                    if_pc_d = pc_q;
                    instr_d = imem_rdata;
                    adel_d  = 1'b0;
                end
            end
            S_HOLD: begin
                // Flush kills the presented instruction even if decode accepts it.
                if (flush) begin
                    pc_d    = flush_pc;
                    state_d = S_FETCH;
                end else if (if_ready) begin
                    pc_d    = npc;
                    state_d = S_FETCH;
                end
            end
            S_DISCARD: begin
                if (flush) begin
                    pc_d = flush_pc;
                end
                if (imem_ack) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Request and address are derived from where the FSM lands next.
        unique case (state_d)
            S_FETCH: begin
                req_d  = !misal_d_c;
                addr_d = pc_d;
            end
            S_DISCARD: begin
                req_d  = 1'b1;
            end
            default: begin
                req_d  = 1'b0;
            end
        endcase
        valid_d = (state_d == S_HOLD);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            valid_q <= 1'b0;
            if_pc_q <= '0;
            instr_q <= '0;
            adel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            if_pc_q <= if_pc_d;
            instr_q <= instr_d;
            adel_q  <= adel_d;
        end
    end

    assign npc4      = pc_q + XLEN'(4);
    assign pc        = pc_q;
    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign if_valid  = valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = instr_q;
    assign if_adel   = ALIGN_CHK ? adel_q : 1'b0;

endmodule
